id_stage_pipe: RTL

Parametrised successor to the ID stage. It keeps the same decode datapath: register-file read addresses, val1/val2 selection, immediate extension and branch-condition check. It adds an owned ID/EX output register with a valid/ready handshake, hazard bubble insertion, branch-flush handling and a stall counter. It sits between the IF/ID register and EXE, consuming controller outputs and register-file read data.

---
 rtl/id_stage_pipe_if.sv | 32 +++
 rtl/id_stage_pipe.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe_if.sv
// Handshake and ID/EX bundle between the IF/ID register, the ID stage and EXE.
// The slave view belongs to the ID stage; the master view belongs to its environment.
interface id_stage_pipe_if #(
    parameter int WORD_LEN    = 32,
    parameter int EXE_CMD_LEN = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WORD_LEN-1:0]    instruction;
    logic                   out_valid;
    logic                   out_ready;
    logic [WORD_LEN-1:0]    ex_val1;
    logic [WORD_LEN-1:0]    ex_val2;
    logic [WORD_LEN-1:0]    ex_st_val;
    logic [4:0]             ex_src1;
    logic [4:0]             ex_src2_forw;
    logic [4:0]             ex_dest;
    logic [EXE_CMD_LEN-1:0] ex_exe_cmd;
    logic [2:0]             ex_ctl;

    modport slave (
        input  in_valid, instruction, out_ready,
        output in_ready, out_valid, ex_val1, ex_val2, ex_st_val,
               ex_src1, ex_src2_forw, ex_dest, ex_exe_cmd, ex_ctl
    );

    modport master (
        output in_valid, instruction, out_ready,
        input  in_ready, out_valid, ex_val1, ex_val2, ex_st_val,
               ex_src1, ex_src2_forw, ex_dest, ex_exe_cmd, ex_ctl
    );
endinterface

// File: rtl/id_stage_pipe.sv
// Instruction decode stage with an owned ID/EX register, valid/ready handshake,
// hazard bubbles, branch flush and a saturating hazard-stall counter.
module id_stage_pipe #(
    parameter int WORD_LEN    = 32,
    parameter int IMM_LEN     = 16,
    parameter bit IMM_SIGNED  = 1'b1,
    parameter int EXE_CMD_LEN = 4,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    id_stage_pipe_if.slave         bus,
    input  logic [WORD_LEN-1:0]    reg1,
    input  logic [WORD_LEN-1:0]    reg2,
    input  logic [EXE_CMD_LEN-1:0] ctl_exe_cmd,
    input  logic [5:0]             ctl_flags,
    input  logic [1:0]             ctl_br_comm,
    input  logic                   hazard_detected,
    input  logic                   flush,
    output logic [4:0]             src1_rd,
    output logic [4:0]             src2_rd,
    output logic                   br_taken,
    output logic [CNT_W-1:0]       stall_cnt
);

    function automatic logic [WORD_LEN-1:0] extend_imm(input logic [IMM_LEN-1:0] imm);
        logic fill;
        fill = IMM_SIGNED ? imm[IMM_LEN-1] : 1'b0;
        return {{(WORD_LEN-IMM_LEN){fill}}, imm};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic branch_en, mem_w_en, mem_r_en, wb_en, st_or_bne, is_imm;
    assign {branch_en, mem_w_en, mem_r_en, wb_en, st_or_bne, is_imm} = ctl_flags;

    logic                   adv;
    logic                   fire;
    logic                   cond;
    logic [WORD_LEN-1:0]    imm_ext;
    logic                   unused_instr;

    logic                   out_valid_q, out_valid_d;
    logic [WORD_LEN-1:0]    val1_q, val1_d;
    logic [WORD_LEN-1:0]    val2_q, val2_d;
    logic [WORD_LEN-1:0]    st_val_q, st_val_d;
    logic [4:0]             src1_q, src1_d;
    logic [4:0]             src2f_q, src2f_d;
    logic [4:0]             dest_q, dest_d;
    logic [EXE_CMD_LEN-1:0] cmd_q, cmd_d;
    logic [2:0]             ctl_q, ctl_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Bits outside the decoded fields are intentionally ignored.
    assign unused_instr = ^bus.instruction;

    assign src1_rd = bus.instruction[20:16];
    assign src2_rd = st_or_bne ? bus.instruction[25:21] : bus.instruction[15:11];
    assign imm_ext = extend_imm(bus.instruction[IMM_LEN-1:0]);

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = flush || (adv && !hazard_detected);
    assign fire         = bus.in_valid && bus.in_ready && !flush;

    always_comb begin
        cond = 1'b0;
        case (ctl_br_comm)
            2'b01:   cond = (reg1 == '0);
            2'b10:   cond = (reg1 != reg2);
            2'b11:   cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    assign br_taken = fire && branch_en && cond;

    // Flush beats bubble beats load; a stalled downstream holds everything.
    always_comb begin
        out_valid_d = out_valid_q;
        val1_d      = val1_q;
        val2_d      = val2_q;
        st_val_d    = st_val_q;
        src1_d      = src1_q;
        src2f_d     = src2f_q;
        dest_d      = dest_q;
        cmd_d       = cmd_q;
        ctl_d       = ctl_q;
        if (flush) begin
            out_valid_d = 1'b0;
            ctl_d       = '0;
        end else if (adv && hazard_detected) begin
            out_valid_d = 1'b0;
            ctl_d       = '0;
        end else if (fire) begin
            out_valid_d = 1'b1;
            val1_d      = reg1;
            val2_d      = is_imm ? imm_ext : reg2;
            st_val_d    = reg2;
            src1_d      = bus.instruction[20:16];
            src2f_d     = is_imm ? 5'd0 : bus.instruction[15:11];
            dest_d      = bus.instruction[25:21];
            cmd_d       = ctl_exe_cmd;
            ctl_d       = {mem_w_en, mem_r_en, wb_en};
        end else if (adv) begin
            out_valid_d = 1'b0;
        end
    end

    assign cnt_d = (bus.in_valid && hazard_detected && !flush) ? sat_inc(cnt_q) : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            val1_q      <= '0;
            val2_q      <= '0;
            st_val_q    <= '0;
            src1_q      <= '0;
            src2f_q     <= '0;
            dest_q      <= '0;
            cmd_q       <= '0;
            ctl_q       <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            val1_q      <= val1_d;
            val2_q      <= val2_d;
            st_val_q    <= st_val_d;
            src1_q      <= src1_d;
            src2f_q     <= src2f_d;
            dest_q      <= dest_d;
            cmd_q       <= cmd_d;
            ctl_q       <= ctl_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.ex_val1      = val1_q;
    assign bus.ex_val2      = val2_q;
    assign bus.ex_st_val    = st_val_q;
    assign bus.ex_src1      = src1_q;
    assign bus.ex_src2_forw = src2f_q;
    assign bus.ex_dest      = dest_q;
    assign bus.ex_exe_cmd   = cmd_q;
    assign bus.ex_ctl       = ctl_q;
    assign stall_cnt        = cnt_q;

endmodule
